// File: rtl/fp32_pkg.sv
// Shared FP32 arithmetic definitions used by the FP32 multiplier and divider.
// Contents:
//   - IEEE-754 single-precision field constants
//   - fp32_unpacked_t : sign, signed 10-bit effective exponent, 24-bit mantissa
//   - div_state_t     : divider FSM states
//   - helpers to unpack an operand and to apply a leading-zero normalization
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;

    typedef struct packed {
        logic                sign;
        logic signed [9:0]   exp;
        logic [MANT_W-1:0]   mant;
    } fp32_unpacked_t;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DIV,
        PACK,
        DONE
    } div_state_t;

    // Subnormals are read as exponent 1 with a hidden bit of 0.
    function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
        fp32_unpacked_t r;
        r.sign = x[31];
        r.exp  = (x[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, x[30:23]});
        r.mant = {x[30:23] != 8'd0, x[FRAC_W-1:0]};
        return r;
    endfunction

    function automatic logic fp32_is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    // Shift the mantissa left so its MSB is set and compensate the exponent.
    function automatic fp32_unpacked_t fp32_normalize(input fp32_unpacked_t op,
                                                      input logic [4:0] lz);
        fp32_unpacked_t r;
        r      = op;
        r.mant = op.mant << lz;
        r.exp  = op.exp - $signed({5'd0, lz});
        return r;
    endfunction

endpackage

// File: rtl/fp32_lzc24.sv
// Combinational 24-bit leading-zero counter.
// Ports:
//   value : 24-bit input word
//   count : number of leading zeros above the highest set bit (24 if value==0)
module fp32_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp32_div.sv
// Iterative FP32 divider, y = a / b, restoring division with one quotient bit
// per cycle. Subnormal inputs are normalized first; the result is truncated.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only when idle)
//   a, b                : dividend and divisor, FP32
//   out_valid/out_ready : result handshake; result held until accepted
//   y                   : quotient, FP32
//   overflow            : exponent saturated high or divide-by-zero
//   underflow           : exponent at or below zero, y flushed to signed zero
//   div_by_zero         : b is zero and a is nonzero
module fp32_div
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    localparam logic signed [9:0] BIAS_HI = 10'(EXP_BIAS);
    localparam logic signed [9:0] BIAS_LO = 10'(EXP_BIAS - 1);
    localparam logic signed [9:0] EXP_SAT = 10'(EXP_MAX);

    div_state_t state_reg, state_next;

    // Index 0 is the dividend, index 1 the divisor.
    logic [1:0][31:0]          operand;
    fp32_unpacked_t [1:0]      in_op;
    fp32_unpacked_t [1:0]      op_reg;
    fp32_unpacked_t [1:0]      norm_op;
    logic [1:0][4:0]           lz;

    logic [25:0] rem_reg;
    logic [25:0] quo_reg;
    logic [4:0]  cnt_reg;

    logic [31:0] y_reg;
    logic        overflow_reg;
    logic        underflow_reg;
    logic        div_by_zero_reg;

    assign operand = {b, a};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign in_op[gi] = fp32_unpack(operand[gi]);

            fp32_lzc24 u_lzc (
                .value (op_reg[gi].mant),
                .count (lz[gi])
            );

            assign norm_op[gi] = fp32_normalize(op_reg[gi], lz[gi]);
        end
    endgenerate

    logic a_zero;
    logic b_zero;
    logic sign_in;
    assign a_zero  = fp32_is_zero(a);
    assign b_zero  = fp32_is_zero(b);
    assign sign_in = a[31] ^ b[31];

    // One restoring step: subtract the divisor when it fits, then shift.
    // The remainder stays below 2*mb so 26 bits are always enough.
    logic [25:0] divisor;
    logic        q_bit;
    logic [25:0] rem_next;
    assign divisor  = {2'b00, op_reg[1].mant};
    assign q_bit    = rem_reg >= divisor;
    assign rem_next = (q_bit ? (rem_reg - divisor) : rem_reg) << 1;

    // Pack: a quotient in [1,2) carries its leading one at bit 25.
    logic signed [9:0] e_res;
    logic [22:0]       frac_res;
    logic              sign_res;
    assign e_res    = op_reg[0].exp - op_reg[1].exp + (quo_reg[25] ? BIAS_HI : BIAS_LO);
    assign frac_res = quo_reg[25] ? quo_reg[24:2] : quo_reg[23:1];
    assign sign_res = op_reg[0].sign ^ op_reg[1].sign;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = (a_zero || b_zero) ? DONE : NORM;
                end
            end
            NORM: state_next = DIV;
            DIV: begin
                if (cnt_reg == 5'd0) begin
                    state_next = PACK;
                end
            end
            PACK: state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg          <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            cnt_reg         <= '0;
            y_reg           <= '0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg <= in_op;
                        if (b_zero && !a_zero) begin
                            y_reg           <= {sign_in, 8'hFF, 23'd0};
                            overflow_reg    <= 1'b1;
                            underflow_reg   <= 1'b0;
                            div_by_zero_reg <= 1'b1;
                        end else if (a_zero) begin
                            y_reg           <= {sign_in, 31'd0};
                            overflow_reg    <= 1'b0;
                            underflow_reg   <= 1'b0;
                            div_by_zero_reg <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    op_reg  <= norm_op;
                    rem_reg <= {2'b00, norm_op[0].mant};
                    quo_reg <= '0;
                    cnt_reg <= 5'd25;
                end
                DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= {quo_reg[24:0], q_bit};
                    cnt_reg <= cnt_reg - 5'd1;
                end
                PACK: begin
                    div_by_zero_reg <= 1'b0;
                    if (e_res >= EXP_SAT) begin
                        y_reg         <= {sign_res, 8'hFF, 23'd0};
                        overflow_reg  <= 1'b1;
                        underflow_reg <= 1'b0;
                    end else if (e_res <= 10'sd0) begin
                        y_reg         <= {sign_res, 31'd0};
                        overflow_reg  <= 1'b0;
                        underflow_reg <= 1'b1;
                    end else begin
                        y_reg         <= {sign_res, e_res[7:0], frac_res};
                        overflow_reg  <= 1'b0;
                        underflow_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign y           = y_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_fp32_div.sv
// Self-checking bench for fp32_div: directed cases with fixed expected values,
// randomized operands against a behavioural reference model, handshake
// back-pressure, ignored in_valid while busy, and mid-operation reset.
module tb_fp32_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp32_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Reference: exact integer quotient of the normalized mantissas, then
    // exponent arithmetic and the flag priority rules. Flags = {ovf, unf, dbz}.
    function automatic void ref_div(input logic [31:0] ra, input logic [31:0] rb,
                                    output logic [31:0] ry, output logic [2:0] rflags,
                                    output int rlat);
        logic        s;
        int          ea, eb, e;
        logic [23:0] ma, mb;
        logic [63:0] q;
        logic [22:0] frac;
        s      = ra[31] ^ rb[31];
        rflags = 3'b000;
        rlat   = 29;
        if (rb[30:0] == 0 && ra[30:0] != 0) begin
            ry = {s, 8'hFF, 23'd0}; rflags = 3'b101; rlat = 1;
            return;
        end
        if (ra[30:0] == 0) begin
            ry = {s, 31'd0}; rlat = 1;
            return;
        end
        ea = (ra[30:23] == 0) ? 1 : int'(ra[30:23]);
        eb = (rb[30:23] == 0) ? 1 : int'(rb[30:23]);
        ma = {ra[30:23] != 0, ra[22:0]};
        mb = {rb[30:23] != 0, rb[22:0]};
        while (!ma[23]) begin ma = ma << 1; ea--; end
        while (!mb[23]) begin mb = mb << 1; eb--; end
        q = ({40'd0, ma} << 25) / {40'd0, mb};
        if (q[25]) begin frac = q[24:2]; e = ea - eb + 127; end
        else       begin frac = q[23:1]; e = ea - eb + 126; end
        if (e >= 255) begin
            ry = {s, 8'hFF, 23'd0}; rflags = 3'b100;
        end else if (e <= 0) begin
            ry = {s, 31'd0}; rflags = 3'b010;
        end else begin
            ry = {s, 8'(e), frac};
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0)       r[30:0]  = 31'd0;
        else if (sel <= 2)  r[30:23] = 8'd0;
        else if (sel <= 12) r[30:23] = 8'($urandom_range(100, 154));
        return r;
    endfunction

    // One full transaction with out_ready held high. If disturb > 0, in_valid
    // is pulsed with junk operands during that cycle after accept.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [31:0] ey, input logic [2:0] ef, input int elat,
                          input int disturb);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            if (lat == disturb) in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".y"}, 64'(y), 64'(ey));
        check({tag, ".flags"}, 64'({overflow, underflow, div_by_zero}), 64'(ef));
        $display("op %s: a=%h b=%h y=%h flags=%b lat=%0d", tag, ta, tbv, y,
                 {overflow, underflow, div_by_zero}, lat);
    endtask

    initial begin
        logic [31:0] ra, rb, ey;
        logic [2:0]  ef;
        int          elat, lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.y", 64'(y), 64'd0);
        check("reset.flags", 64'({overflow, underflow, div_by_zero}), 64'd0);
        rst = 1'b0;

        // Directed cases with hand-derived results
        run_op("six_div_two",  32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29, 0);
        run_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 29, 5);
        run_op("subnormal_a",  32'h00400000, 32'h3F000000, 32'h00800000, 3'b000, 29, 0);
        run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 29, 0);
        run_op("div_by_zero",  32'h3F800000, 32'h80000000, 32'hFF800000, 3'b101, 1, 0);
        run_op("zero_dividend", 32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1, 0);
        run_op("zero_by_zero", 32'h00000000, 32'h80000000, 32'h80000000, 3'b000, 1, 0);
        run_op("overflow",     32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100, 29, 0);

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            ref_div(ra, rb, ey, ef, elat);
            run_op($sformatf("rand%0d", i), ra, rb, ey, ef, elat,
                   (i % 4 == 0) ? int'($urandom_range(2, 27)) : 0);
        end

        // Back-pressure: result must hold while out_ready is low
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        check("hold.latency", 64'(lat), 64'd29);
        for (int i = 0; i < 10; i++) begin
            check("hold.y", 64'(y), 64'h40400000);
            check("hold.in_ready", 64'(in_ready), 64'd0);
            check("hold.out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold.release_out_valid", 64'(out_valid), 64'd0);
        check("hold.release_in_ready", 64'(in_ready), 64'd1);
        $display("op hold: y=%h held 10 cycles", 32'h40400000);

        // Reset in the middle of a division
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin @(negedge clk); lat++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset.in_ready", 64'(in_ready), 64'd1);
        check("midreset.out_valid", 64'(out_valid), 64'd0);
        check("midreset.y", 64'(y), 64'd0);
        check("midreset.flags", 64'({overflow, underflow, div_by_zero}), 64'd0);
        $display("op midreset: outputs after reset y=%h", y);
        run_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 29, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp32_div.md
# fp32_div

Iterative FP32 divider computing y = a / b using restoring division, one quotient bit per cycle. It is the inverse-operation companion to the combinational FP32 multiplier in the arithmetic datapath and uses the same number conventions: subnormal inputs are interpreted as exponent 1 with hidden bit 0, and results are truncated with no rounding. Operands enter through a valid/ready input handshake, and the result leaves through a valid/ready output handshake.

## Interface
No parameters; widths are fixed to IEEE-754 single precision.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair a/b valid
- in_ready  out  1  divider idle and able to accept operands
- a  in  32  dividend, FP32
- b  in  32  divisor, FP32
- out_valid  out  1  result fields valid; held until accepted
- out_ready  in  1  consumer accepts result
- y  out  32  quotient, FP32, truncated
- overflow  out  1  result exponent ≥ 255 or divide-by-zero
- underflow  out  1  result exponent ≤ 0; y flushed to signed zero
- div_by_zero  out  1  b is ±0 and a is nonzero

## Operation
- **Decode.** Sign s = a[31]^b[31]. For each operand: e' = (exp==0) ? 1 : exp, m = {exp!=0, frac} (24 bits). An operand is zero when exp==0 and frac==0.
- **Normalize (subnormals).** Left-shift each m by its leading-zero count lz so that m[23]=1. Then e_eff = e' − lz, held as a signed 10-bit value.
- **Divide.** Q = floor(ma·2^25 / mb), 26 bits. Computed by a 26-iteration restoring divider: a 26-bit partial remainder and 26-bit quotient shift register, producing one bit per iteration, MSB first.
- **Pack.**
  - If Q[25]: frac = Q[24:2], E = ea − eb + 127.
  - Else: frac = Q[23:1], E = ea − eb + 126.
  - The remaining quotient bits and the remainder are discarded (truncate).
- **Result selection, in priority order:**
  - b zero and a nonzero → y = {s, 8'hFF, 0}, overflow=1, div_by_zero=1.
  - a zero (including a and b both zero) → y = {s, 31'd0}, all flags 0.
  - E ≥ 255 → y = {s, 8'hFF, 0}, overflow=1.
  - E ≤ 0 → y = {s, 31'd0}, underflow=1.
  - Otherwise → y = {s, E[7:0], frac}.
- **Inf/NaN.** Not special-cased: exponent 255 inputs are treated as finite values.
- **FSM states:** IDLE, NORM, DIV, PACK, DONE.
  - IDLE → NORM on in_valid; operands are latched.
  - IDLE → DONE directly when either operand is zero (special case).
  - NORM → DIV after one cycle; the lz shift is applied here.
  - DIV holds for 26 cycles, counted by a 5-bit counter from 25 down to 0, then goes to PACK.
  - PACK → DONE after one cycle; the output registers are loaded here.
  - DONE → IDLE on out_ready.
- in_ready = (state==IDLE). Operands are never accepted while busy.

## Timing
- Accept edge: the rising edge where in_valid & in_ready are both high; call it T.
- Normal path:
  - NORM during cycle T+1.
  - DIV during cycles T+2..T+27.
  - PACK during cycle T+28.
  - out_valid high from cycle T+29.
  - Latency is 29 cycles from accept to out_valid.
- Zero-operand path: out_valid is high in cycle T+1 (latency 1).
- In DONE, y and all flags are registered and stable until the edge where out_valid & out_ready are both high. The FSM returns to IDLE on that edge, so in_ready rises one cycle later.
- Back-to-back throughput: one operation per 30 cycles minimum when out_ready is held high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, overflow=0, underflow=0, div_by_zero=0.
- Reset asserted in any state aborts the operation on the next edge and returns all outputs to their reset values. No partial result is ever emitted.
- in_valid while not in IDLE is ignored; the operands are not latched.
- a and b are sampled only at the accept edge; changes afterwards have no effect.

## Structure
- **Shared package fp32_pkg:**
  - Field constants: EXP_BIAS=127, EXP_MAX=255, FRAC_W=23, MANT_W=24.
  - Typedef for the unpacked operand: sign, signed 10-bit exponent, 24-bit mantissa.
  - FSM state enum.
  - Both the multiplier and the divider reference this package.
- **Sub-module fp32_lzc24:** combinational 24-bit leading-zero counter producing a 5-bit count (24 when the input is all zero). Instantiated once per operand.
- The divider core (remainder, quotient, counter) stays inside fp32_div.

## Test plan
- 6.0 / 2.0: a=0x40C00000, b=0x40000000 → y=0x40400000, no flags, out_valid exactly 29 cycles after accept.
- 1.0 / 3.0: a=0x3F800000, b=0x40400000 → y=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- Subnormal dividend: a=0x00400000, b=0x3F000000 → y=0x00800000. Underflow case: a=0x00800000, b=0x40000000 → y=0x00000000, underflow=1.
- Special cases:
  - a=0x3F800000, b=0x80000000 → y=0xFF800000, overflow=1, div_by_zero=1, latency 1.
  - a=0x80000000, b=0x40000000 → y=0x80000000, flags 0.
- Overflow: a=0x7F000000, b=0x00800000 → y=0x7F800000, overflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE → y stable and in_ready=0 throughout.
  - Pulse in_valid during DIV → ignored.
  - Assert rst at cycle T+10 → all outputs at reset values next cycle; the next operation returns a correct result.
